instr_mem_responder: RTL



---
 rtl/riscv_ifu_pkg.sv | 15 +
 rtl/instr_mem_responder_sync_fifo.sv | 50 +++++
 rtl/instr_mem_responder.sv | 95 +++++++++
 3 files changed

// File: rtl/riscv_ifu_pkg.sv
// Shared types for the instruction-fetch interface: instruction word, NOP encoding
// and the response record carried through the responder pipeline and FIFO.
package riscv_ifu_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef logic [XLEN-1:0] instr_t;

  typedef struct packed {
    instr_t instr;
    logic   error;
  } ifu_rsp_t;

endpackage

// File: rtl/instr_mem_responder_sync_fifo.sv
// Synchronous first-word fall-through FIFO with full/empty flags; a push into a
// full FIFO is honoured when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = store[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory responder: accepts fetch addresses, returns instruction words
// in order after a fixed pipeline latency; a side port loads program words.
module instr_mem_responder
  import riscv_ifu_pkg::*;
#(
  parameter int DEPTH_WORDS    = 64,
  parameter int LATENCY        = 2,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [XLEN-1:0]                     req_addr,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [XLEN-1:0]                     rsp_instr,
  output logic                                rsp_error,
  input  logic                                load_en,
  input  logic [XLEN-1:0]                     load_addr,
  input  logic [XLEN-1:0]                     load_data,
  output logic [$clog2(RSP_FIFO_DEPTH):0]     outstanding
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(RSP_FIFO_DEPTH) + 1;

  instr_t   mem [DEPTH_WORDS];
  logic     accept;
  logic     pop;
  logic     req_bad;
  logic     load_ok;
  logic     stg_valid [LATENCY];
  ifu_rsp_t stg_data  [LATENCY];
  logic     fifo_push;
  logic     fifo_full;
  logic     fifo_empty;
  ifu_rsp_t fifo_head;

  // Credit check counts pipeline plus FIFO, so a pipeline result always finds a slot.
  assign req_ready = !reset && !load_en && (outstanding < CW'(RSP_FIFO_DEPTH));
  assign accept    = req_valid && req_ready;

  assign req_bad = (req_addr[1:0] != 2'b00) || (req_addr[XLEN-1:AW+2] != '0);
  assign load_ok = load_en && (load_addr[1:0] == 2'b00) && (load_addr[XLEN-1:AW+2] == '0);

  always_ff @(posedge clock) begin
    if (load_ok) mem[load_addr[AW+1:2]] <= load_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) stg_valid[i] <= 1'b0;
    end else begin
      stg_valid[0] <= accept;
      for (int i = 1; i < LATENCY; i++) stg_valid[i] <= stg_valid[i-1];
    end
  end

  // Stage 0 performs the memory read; bad addresses substitute a NOP.
  always_ff @(posedge clock) begin
    if (accept) begin
      if (req_bad) stg_data[0] <= '{instr: NOP_INSTR, error: 1'b1};
      else         stg_data[0] <= '{instr: mem[req_addr[AW+1:2]], error: 1'b0};
    end
    for (int i = 1; i < LATENCY; i++) stg_data[i] <= stg_data[i-1];
  end

  assign fifo_push = stg_valid[LATENCY-1] && (!fifo_full || pop);

  sync_fifo #(
    .WIDTH ($bits(ifu_rsp_t)),
    .DEPTH (RSP_FIFO_DEPTH)
  ) u_rsp_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (stg_data[LATENCY-1]),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid && rsp_ready;
  assign rsp_instr = rsp_valid ? fifo_head.instr : '0;
  assign rsp_error = rsp_valid ? fifo_head.error : 1'b0;

  always_ff @(posedge clock) begin
    if (reset) outstanding <= '0;
    else       outstanding <= outstanding + CW'(accept) - CW'(pop);
  end

endmodule
